result_writeback: RTL and testbench



---
 rtl/kf_router_pkg.sv | 34 +++
 rtl/wb_fifo2.sv | 49 ++++
 rtl/result_writeback.sv | 85 ++++++++
 tb/tb_result_writeback.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kf_router_pkg.sv
// Shared definitions for the operand router and its result write-back path.
package kf_router_pkg;

    // Default datapath width shared by router and write-back.
    localparam int W_DEFAULT = 24;

    // Write-back destination codes carried with each result.
    localparam logic [1:0] DEST_RQ   = 2'b00;
    localparam logic [1:0] DEST_RD   = 2'b01;
    localparam logic [1:0] DEST_MEM  = 2'b10;
    localparam logic [1:0] DEST_DROP = 2'b11;

    // Operand router R-mux selects.
    typedef enum logic [1:0] {
        R_SEL_RQ   = 2'b00,
        R_SEL_RD   = 2'b01,
        R_SEL_A    = 2'b10,
        R_SEL_ZERO = 2'b11
    } r_sel_e;

    // Operand router S-mux selects.
    typedef enum logic [1:0] {
        S_SEL_RQ   = 2'b00,
        S_SEL_RD   = 2'b01,
        S_SEL_B    = 2'b10,
        S_SEL_ZERO = 2'b11
    } s_sel_e;

    // True when a destination can retire without waiting on the memory port.
    function automatic logic retires_freely(input logic [1:0] dest);
        return dest != DEST_MEM;
    endfunction

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry in-order FIFO with one-bit wrap-around pointers.
module wb_fifo2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [1:0]    count,
    output logic [DW-1:0] head
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    // Ignore push when full and pop when empty so the count can never wrap.
    assign push_ok = push && (count != 2'd2);
    assign pop_ok  = pop  && (count != 2'd0);
    assign head    = mem[rd_ptr];

    // Storage has no reset; an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together keep count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr <= ~wr_ptr;
            if (pop_ok)  rd_ptr <= ~rd_ptr;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/result_writeback.sv
// Result write-back: queues ALU/divider results and retires them in order
// into the RQ/RD holding registers or out to the data-memory write port.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Ready never depends on valid. Once mem_wr_valid is high, the
// address and data hold steady until mem_wr_ready is seen.
module result_writeback
    import kf_router_pkg::*;
#(
    parameter int W  = W_DEFAULT,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic [1:0]    in_dest,
    input  logic [AW-1:0] in_addr,
    input  logic          in_inv,
    output logic [W-1:0]  RQ,
    output logic [W-1:0]  RD,
    output logic          mem_wr_valid,
    input  logic          mem_wr_ready,
    output logic [AW-1:0] mem_wr_addr,
    output logic [W-1:0]  mem_wr_data,
    output logic          busy
);

    localparam int EW = AW + 2 + W;

    logic [EW-1:0] push_entry;
    logic [EW-1:0] head_entry;
    logic [1:0]    count;
    logic          push;
    logic          pop;
    logic          has_head;
    logic [W-1:0]  head_data;
    logic [1:0]    head_dest;
    logic [AW-1:0] head_addr;

    // Full buffer refuses input even if the head retires this cycle.
    assign in_ready   = !rst && (count != 2'd2);
    assign push       = in_valid && in_ready;
    // Inversion is applied on entry so the buffer holds final values.
    assign push_entry = {in_addr, in_dest, (in_inv ? ~in_data : in_data)};

    assign head_data  = head_entry[W-1:0];
    assign head_dest  = head_entry[W+1:W];
    assign head_addr  = head_entry[EW-1:W+2];
    assign has_head   = (count != 2'd0);

    // A MEM head blocks everything behind it until memory accepts it.
    assign pop = has_head && (retires_freely(head_dest) || mem_wr_ready);

    assign mem_wr_valid = has_head && (head_dest == DEST_MEM);
    assign mem_wr_addr  = head_addr;
    assign mem_wr_data  = head_data;
    assign busy         = has_head;

    wb_fifo2 #(.DW(EW)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .count     (count),
        .head      (head_entry)
    );

    // Holding registers load from the head as it retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            RQ <= '0;
            RD <= '0;
        end else if (pop) begin
            case (head_dest)
                DEST_RQ: RQ <= head_data;
                DEST_RD: RD <= head_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_result_writeback.sv
// Bench for result_writeback: reference queue model, memory-write scoreboard
// and directed scenarios followed by a random phase.
module tb_result_writeback;
    import kf_router_pkg::*;

    localparam int W  = 24;
    localparam int AW = 6;

    typedef struct packed {
        logic [1:0]    dest;
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } ent_t;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [1:0]    in_dest = '0;
    logic [AW-1:0] in_addr = '0;
    logic          in_inv = 1'b0;
    logic [W-1:0]  RQ;
    logic [W-1:0]  RD;
    logic          mem_wr_valid;
    logic          mem_wr_ready = 1'b0;
    logic [AW-1:0] mem_wr_addr;
    logic [W-1:0]  mem_wr_data;
    logic          busy;

    always #5 clk = ~clk;

    result_writeback #(.W(W), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_dest      (in_dest),
        .in_addr      (in_addr),
        .in_inv       (in_inv),
        .RQ           (RQ),
        .RD           (RD),
        .mem_wr_valid (mem_wr_valid),
        .mem_wr_ready (mem_wr_ready),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .busy         (busy)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    ent_t                m_q[$];
    logic [W-1:0]        m_rq = '0;
    logic [W-1:0]        m_rd = '0;
    logic [AW+W-1:0]     exp_q[$];

    always @(posedge clk) begin
        ent_t h;
        ent_t e;
        logic push_ok;
        if (rst) begin
            m_q.delete();
            exp_q.delete();
            m_rq = '0;
            m_rd = '0;
        end else begin
            push_ok = in_valid && (m_q.size() < 2);
            if (m_q.size() != 0) begin
                h = m_q[0];
                if (h.dest != DEST_MEM || mem_wr_ready) begin
                    if (h.dest == DEST_RQ) m_rq = h.data;
                    if (h.dest == DEST_RD) m_rd = h.data;
                    void'(m_q.pop_front());
                end
            end
            if (push_ok) begin
                e.dest = in_dest;
                e.addr = in_addr;
                e.data = in_inv ? ~in_data : in_data;
                m_q.push_back(e);
                if (in_dest == DEST_MEM) exp_q.push_back({in_addr, e.data});
            end
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [AW+W-1:0] x;
        check("in_ready", in_ready, !rst && (m_q.size() < 2));
        check("busy", busy, m_q.size() != 0);
        check("mem_wr_valid", mem_wr_valid, (m_q.size() != 0) && (m_q[0].dest == DEST_MEM));
        check("RQ", RQ, m_rq);
        check("RD", RD, m_rd);
        if (m_q.size() != 0 && m_q[0].dest == DEST_MEM) begin
            check("mem_wr_addr", mem_wr_addr, m_q[0].addr);
            check("mem_wr_data", mem_wr_data, m_q[0].data);
        end
        if (!rst && mem_wr_valid && mem_wr_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_write", {31'd0, mem_wr_valid}, 32'd0);
            end else begin
                x = exp_q.pop_front();
                check("sb_addr", mem_wr_addr, x[AW+W-1:W]);
                check("sb_data", mem_wr_data, x[W-1:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one result and hold it until the model says it was taken.
    task automatic push_one(input logic [W-1:0] d, input logic [1:0] dest,
                            input logic [AW-1:0] a, input logic inv);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_dest  = dest;
        in_addr  = a;
        in_inv   = inv;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = !rst && (m_q.size() < 2);
            tick();
        end
        if (!acc) check("push_timeout", {31'd0, acc}, 32'd1);
        in_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] last_rq;
        logic [W-1:0] last_rd;
        logic [W-1:0] d;
        logic [1:0]   dsel;
        logic         inv;

        repeat (3) tick();
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_RQ", RQ, 0);
        check("rst_busy", busy, 0);
        #1 rst = 1'b0;
        tick();
        check("post_rst_in_ready", in_ready, 1);

        // Single RQ write.
        push_one(24'h123456, DEST_RQ, '0, 1'b0);
        tick();
        check("t1_RQ", RQ, 24'h123456);
        check("t1_RD", RD, 24'h0);
        check("t1_busy", busy, 0);

        // Inverted RD write.
        push_one(24'h0FF00D, DEST_RD, '0, 1'b1);
        tick();
        check("t2_RD", RD, 24'hF00FF2);
        check("t2_RD_msb", RD[W-1], 1);

        // Stalled memory write.
        mem_wr_ready = 1'b0;
        push_one(24'hABCDEF, DEST_MEM, 6'h2A, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("t3_valid", mem_wr_valid, 1);
            check("t3_addr", mem_wr_addr, 6'h2A);
            check("t3_data", mem_wr_data, 24'hABCDEF);
            tick();
        end
        mem_wr_ready = 1'b1;
        tick();
        check("t3_retired_busy", busy, 0);
        check("t3_retired_valid", mem_wr_valid, 0);

        // Ordering behind a stalled MEM write, and full-buffer backpressure.
        mem_wr_ready = 1'b0;
        push_one(24'h111111, DEST_MEM, 6'h05, 1'b0);
        push_one(24'hC0FFEE, DEST_RQ, '0, 1'b0);
        in_valid = 1'b1;
        in_data  = 24'h222222;
        in_dest  = DEST_RD;
        in_inv   = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t4_full_ready", in_ready, 0);
            check("t4_RQ_held", RQ, 24'h123456);
            tick();
        end
        mem_wr_ready = 1'b1;
        tick();
        check("t4_RQ_after_mem", RQ, 24'h123456);
        tick();
        in_valid = 1'b0;
        check("t4_RQ_final", RQ, 24'hC0FFEE);
        tick();
        check("t4_RD_final", RD, 24'h222222);

        // Back-to-back register/discard traffic.
        last_rq = RQ;
        last_rd = RD;
        for (int i = 0; i < 8; i++) begin
            d    = W'($urandom_range(0, 24'hFFFFFF));
            inv  = 1'($urandom_range(0, 1));
            dsel = (i % 3 == 0) ? DEST_RQ : (i % 3 == 1) ? DEST_RD : DEST_DROP;
            if (dsel == DEST_RQ) last_rq = inv ? ~d : d;
            if (dsel == DEST_RD) last_rd = inv ? ~d : d;
            in_valid = 1'b1;
            in_data  = d;
            in_dest  = dsel;
            in_inv   = inv;
            @(negedge clk);
            check("t5_ready", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("t5_RQ_last", RQ, last_rq);
        check("t5_RD_last", RD, last_rd);

        // Reset with work queued.
        mem_wr_ready = 1'b0;
        push_one(24'h777777, DEST_MEM, 6'h3F, 1'b0);
        push_one(24'h555555, DEST_RQ, '0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_RQ", RQ, 0);
        check("t6_RD", RD, 0);
        check("t6_valid", mem_wr_valid, 0);
        check("t6_busy", busy, 0);
        mem_wr_ready = 1'b1;
        repeat (3) tick();
        check("t6_RQ_later", RQ, 0);
        check("t6_busy_later", busy, 0);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            in_valid     = 1'($urandom_range(0, 1));
            in_data      = W'($urandom_range(0, 24'hFFFFFF));
            in_dest      = 2'($urandom_range(0, 3));
            in_addr      = AW'($urandom_range(0, 63));
            in_inv       = 1'($urandom_range(0, 1));
            mem_wr_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid     = 1'b0;
        mem_wr_ready = 1'b1;
        repeat (5) tick();
        check("drain_sb_empty", exp_q.size(), 0);
        check("drain_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
